// File: rtl/tbus_arbiter.sv
// tbus_arbiter: shares one tbus port between the IFU and LSU requesters.
//   - Round-robin between the two requesters; after reset the LSU wins a tie.
//   - One transaction in flight; the grant stays locked from acceptance until
//     tbus_operation_done.
//   - Requests are forwarded combinationally: zero arbitration latency, no
//     payload registers.
//   - The response goes to the owner only; the non-owner always sees zeros.
// Ports:
//   clock, reset                   clock; asynchronous active-high reset
//   {ifu,lsu}_index_*              requester request channel (valid/ready)
//   {ifu,lsu}_write_data/mask/op   request payload
//   {ifu,lsu}_read_data/done       response to the requester
//   tbus_*                         downstream slave port

`ifndef TBUS_RANGE
`define TBUS_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b01
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b10
`endif

module tbus_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU requester
  input  logic                  ifu_index_valid,
  output logic                  ifu_index_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_index,
  input  logic [DATA_WIDTH-1:0] ifu_write_data,
  input  logic [63:0]           ifu_write_mask,
  input  logic [`TBUS_RANGE]    ifu_operation_type,
  output logic [DATA_WIDTH-1:0] ifu_read_data,
  output logic                  ifu_operation_done,
  // LSU requester
  input  logic                  lsu_index_valid,
  output logic                  lsu_index_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_index,
  input  logic [DATA_WIDTH-1:0] lsu_write_data,
  input  logic [63:0]           lsu_write_mask,
  input  logic [`TBUS_RANGE]    lsu_operation_type,
  output logic [DATA_WIDTH-1:0] lsu_read_data,
  output logic                  lsu_operation_done,
  // downstream slave
  output logic                  tbus_index_valid,
  input  logic                  tbus_index_ready,
  output logic [ADDR_WIDTH-1:0] tbus_index,
  output logic [DATA_WIDTH-1:0] tbus_write_data,
  output logic [63:0]           tbus_write_mask,
  output logic [`TBUS_RANGE]    tbus_operation_type,
  input  logic [DATA_WIDTH-1:0] tbus_read_data,
  input  logic                  tbus_operation_done
);

  typedef enum logic [1:0] {IDLE, PENDING, OUTSTANDING} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] wdata;
    logic [63:0]           wmask;
    logic [`TBUS_RANGE]    op;
  } req_t;

  state_t state;
  logic   owner;       // 0 = IFU, 1 = LSU
  logic   last_grant;  // owner of the last completed transaction
  logic   sel;         // requester currently steering the mux
  logic   act;         // selected requester is presenting a request
  logic   fire;
  logic   resp_live;
  req_t   ifu_req, lsu_req, mux_req;

  assign ifu_req = '{ifu_index, ifu_write_data, ifu_write_mask, ifu_operation_type};
  assign lsu_req = '{lsu_index, lsu_write_data, lsu_write_mask, lsu_operation_type};

  // Arbitrate only in IDLE; once PENDING the latched owner holds the mux so
  // a late-arriving requester cannot steal a stalled grant.
  always_comb begin
    sel = owner;
    act = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_index_valid && lsu_index_valid) sel = ~last_grant;
        else                                    sel = lsu_index_valid;
        act = ifu_index_valid | lsu_index_valid;
      end
      PENDING: act = owner ? lsu_index_valid : ifu_index_valid;
      default: act = 1'b0;
    endcase
  end

  always_comb begin
    mux_req = '0;
    if (act) mux_req = sel ? lsu_req : ifu_req;
  end

  assign tbus_index_valid    = act;
  assign tbus_index          = mux_req.index;
  assign tbus_write_data     = mux_req.wdata;
  assign tbus_write_mask     = mux_req.wmask;
  assign tbus_operation_type = mux_req.op;

  assign fire            = act & tbus_index_ready;
  assign ifu_index_ready = fire & ~sel;
  assign lsu_index_ready = fire &  sel;

  // Done outside OUTSTANDING is stale or spurious and is dropped.
  assign resp_live          = (state == OUTSTANDING) & tbus_operation_done;
  assign ifu_operation_done = resp_live & ~owner;
  assign lsu_operation_done = resp_live &  owner;
  assign ifu_read_data      = ifu_operation_done ? tbus_read_data : '0;
  assign lsu_read_data      = lsu_operation_done ? tbus_read_data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: if (act) begin
          owner <= sel;
          state <= tbus_index_ready ? OUTSTANDING : PENDING;
        end
        // Owner withdrawing its request is a flush: nothing happened, so
        // last_grant keeps its old value.
        PENDING: begin
          if (!act)      state <= IDLE;
          else if (fire) state <= OUTSTANDING;
        end
        OUTSTANDING: if (tbus_operation_done) begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tbus_arbiter.md
# tbus_arbiter

Two-requester arbiter that shares the single trinity bus (tbus) port between the instruction-fetch requester (IFU) and the memory-stage load/store requester (LSU). It sits between both front-end/back-end masters and the tbus slave (cache or memory model). It keeps at most one transaction in flight, locks the grant from request acceptance until `operation_done`, and routes the response back to the owning requester only. Arbitration is round-robin between the two requesters.

## Interface
- `ADDR_WIDTH`, 64: tbus index width.
- `DATA_WIDTH`, 64: read/write data width. The write mask is always 64 bits (byte-lane bits as produced by the LSU).
- `clock`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ifu_index_valid` / `lsu_index_valid`  in  1  request valid per requester.
- `ifu_index_ready` / `lsu_index_ready`  out  1  request accepted.
- `ifu_index` / `lsu_index`  in  ADDR_WIDTH  request address.
- `ifu_write_data` / `lsu_write_data`  in  DATA_WIDTH  store data.
- `ifu_write_mask` / `lsu_write_mask`  in  64  store byte mask.
- `ifu_operation_type` / `lsu_operation_type`  in  `TBUS_RANGE  `TBUS_READ` or `TBUS_WRITE`.
- `ifu_read_data` / `lsu_read_data`  out  DATA_WIDTH  response data.
- `ifu_operation_done` / `lsu_operation_done`  out  1  response strobe.
- `tbus_index_valid`  out  1  downstream request valid.
- `tbus_index_ready`  in  1  downstream accept.
- `tbus_index`  out  ADDR_WIDTH.
- `tbus_write_data`  out  DATA_WIDTH.
- `tbus_write_mask`  out  64.
- `tbus_operation_type`  out  `TBUS_RANGE.
- `tbus_read_data`  in  DATA_WIDTH.
- `tbus_operation_done`  in  1  downstream completion strobe.

## Operation
- **State:** `state` ∈ {IDLE, PENDING, OUTSTANDING}; `owner` (0 = IFU, 1 = LSU); `last_grant` (same encoding).
- **Reset values:** `state` = IDLE, `owner` = 0, `last_grant` = 0 (IFU). With these values the LSU wins the first tie.
- **Grant select in IDLE (combinational):**
  - Only one requester valid: that requester is selected.
  - Both valid: the requester ≠ `last_grant` is selected.
  - Neither valid: `tbus_index_valid` = 0.
- **Request forwarding:**
  - The selected requester's index, data, mask and type go to `tbus_*` in the same cycle.
  - `tbus_index_valid` equals that requester's valid.
  - Only the selected requester sees `*_index_ready` = `tbus_index_ready`. The other requester sees ready = 0.
- **IDLE transitions:**
  - Fire (valid & ready): go to OUTSTANDING, latch `owner`.
  - Valid without ready: go to PENDING, latch `owner`.
- **PENDING:**
  - The mux is driven by the latched `owner`, not by re-arbitration.
  - Fire: go to OUTSTANDING.
  - Owner drops valid (flush): go to IDLE. No transaction occurred and `last_grant` is unchanged.
- **OUTSTANDING:**
  - `tbus_index_valid` = 0 and all `*_index_ready` = 0.
  - On `tbus_operation_done`:
    - Drive the owner's `*_operation_done` = 1 and `*_read_data` = `tbus_read_data` in that cycle.
    - Set `last_grant` ← `owner`.
    - Go to IDLE.
- **Response routing:**
  - Non-owner `*_operation_done` = 0 and `*_read_data` = 0 at all times.
  - `tbus_operation_done` in IDLE or PENDING is ignored: it is forwarded to nobody and causes no state change.
- **Write transactions:** follow the same path. `read_data` is forwarded unchanged and is don't-care for stores.
- **Idle output values:** when nothing is selected, `tbus_index`, `tbus_write_data`, `tbus_write_mask` and `tbus_operation_type` are 0.

## Timing
- **Arbitration latency:** 0 cycles. A request arriving in IDLE with the slave ready fires in the same cycle.
- **Done:** valid no earlier than 1 cycle after fire. Done in the fire cycle is not supported and is ignored.
- **Owner notification:** in the same cycle as `tbus_operation_done` (combinational pass-through).
- **Next request:**
  - Earliest downstream request after a done is the following cycle (IDLE).
  - Back-to-back throughput is therefore one transaction per 2 cycles minimum (fire at N, done at N+1, next fire at N+2).
- **Starvation bound:** with both requesters continuously valid, grants strictly alternate.
- **Reset mid-operation:** the async assertion forces IDLE immediately and drops the in-flight transaction. A stale `tbus_operation_done` after reset release is ignored because the block is in IDLE.
- **Stability requirement:** requesters hold request fields stable while valid and not ready. The arbiter does not register request payloads.

## Test plan
- **Single LSU read:** LSU requests read at 0x80001000, `tbus_index_ready`=1 in cycle 0, done at cycle 3 with data 0xDEAD_BEEF -> `tbus_index`=0x80001000 in cycle 0; `lsu_operation_done`=1 and `lsu_read_data`=0xDEAD_BEEF in cycle 3; `ifu_operation_done`=0 throughout.
- **Simultaneous first requests after reset:** IFU and LSU both valid -> LSU granted first. IFU granted in the IDLE cycle after LSU's done. Grants then alternate over 4 transactions: LSU, IFU, LSU, IFU.
- **Backpressure:** IFU read with `tbus_index_ready`=0 for 3 cycles while LSU also becomes valid -> state PENDING, IFU stays owner, `lsu_index_ready`=0, fire on cycle 3, LSU served after IFU's done.
- **LSU store passthrough:** `lsu_write_mask`=0x0000_0000_FF00_0000 and `lsu_write_data`=0xAB00_0000 -> identical `tbus_write_mask`/`tbus_write_data`, `tbus_operation_type`=`TBUS_WRITE`, `lsu_operation_done` pulses 1 cycle.
- **Spurious done and flush:**
  - `tbus_operation_done`=1 in IDLE -> no requester done, state IDLE.
  - LSU drops valid in PENDING -> IDLE, `last_grant` unchanged.
- **Reset mid-transaction:** assert `reset` in OUTSTANDING, then deliver done after release -> no `*_operation_done` asserted. The next request is granted normally.
